// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction fields, noop encoding, fetch-stage actions.
package mips_pkg;

    localparam logic [5:0]  OPCODE_NOOP = 6'b111111;
    localparam logic [31:0] NOP_WORD    = {OPCODE_NOOP, 26'b0};

    // Instruction field slices
    localparam int OP_HI      = 31;
    localparam int OP_LO      = 26;
    localparam int J_INDEX_HI = 25;
    localparam int J_INDEX_LO = 0;

    localparam int unsigned WORD_BYTES = 4;

    // What the fetch stage does with PC and IF/ID on the coming edge
    typedef enum logic [2:0] {
        ACT_BRANCH,   // redirect to branch target, bubble IF/ID
        ACT_JUMP,     // redirect to J-format target, bubble IF/ID
        ACT_FLUSH,    // bubble IF/ID, pc advances unless stalled
        ACT_HOLD,     // stall: pc and IF/ID hold
        ACT_SEQ       // normal fetch
    } fetch_act_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: redirect/flush/stall/increment priority and target alignment.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int unsigned PC_STEP = WORD_BYTES
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [3:0]  pc4_hi,
    output logic [31:0] pc_inc,
    output logic [31:0] pc_next,
    output fetch_act_e  act,
    output logic        misalign_set
);

    assign pc_inc = pc + 32'(PC_STEP);

    // Branch is older than jump, so it wins; redirects ignore stall since
    // the squashed slot must not be held.
    always_comb begin
        act          = ACT_SEQ;
        pc_next      = pc_inc;
        misalign_set = 1'b0;
        if (branch_taken) begin
            act          = ACT_BRANCH;
            pc_next      = {branch_target[31:2], 2'b00};
            misalign_set = (branch_target[1:0] != 2'b00);
        end else if (jump) begin
            act     = ACT_JUMP;
            pc_next = {pc4_hi, jump_index, 2'b00};
        end else if (flush) begin
            act     = ACT_FLUSH;
            pc_next = stall ? pc : pc_inc;
        end else if (stall) begin
            act     = ACT_HOLD;
            pc_next = pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC register, IF/ID pipeline register, fetch counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD,
    parameter int unsigned PC_STEP  = mips_pkg::WORD_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        misalign,
    output logic [31:0] fetch_count
);
    import mips_pkg::*;

    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [31:0] pc_next;
    fetch_act_e  act;
    logic        misalign_set;

    // Memory is combinational: address straight from the PC register
    assign imem_addr = pc;

    pc_next_sel #(
        .PC_STEP(PC_STEP)
    ) u_sel (
        .pc           (pc),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_index   (jump_index),
        .pc4_hi       (if_id_pc4[31:28]),
        .pc_inc       (pc_inc),
        .pc_next      (pc_next),
        .act          (act),
        .misalign_set (misalign_set)
    );

    // PC, IF/ID and counters; redirect/flush bubbles keep if_id_pc4 as-is
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP_WORD;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            misalign    <= 1'b0;
            fetch_count <= 32'h0;
        end else begin
            pc <= pc_next;
            case (act)
                ACT_SEQ: begin
                    if_id_instr <= imem_data;
                    if_id_pc4   <= pc_inc;
                    if_id_valid <= 1'b1;
                    fetch_count <= fetch_count + 32'h1;
                end
                ACT_HOLD: ;
                default: begin
                    if_id_instr <= NOP_WORD;
                    if_id_valid <= 1'b0;
                end
            endcase
            if (misalign_set)
                misalign <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational memory model.
module tb_fetch_stage;

    logic        clk = 0;
    logic        reset;
    logic        stall, flush, branch_taken, jump;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] if_id_instr, if_id_pc4, fetch_count;
    logic        if_id_valid, misalign;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'hFC000000;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .misalign(misalign),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // addi/sw/lw/add at 0x0..0xC, address-tagged words elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h20080005;
            32'h4:   return 32'hAC080000;
            32'h8:   return 32'h8C090000;
            32'hC:   return 32'h01095020;
            default: return {16'h2000, a[17:2]};
        endcase
    endfunction

    always_comb imem_data = mem_word(imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_index = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        #3;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0); end
        checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", if_id_instr, NOP); end
        checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", if_id_pc4); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
        step();
        reset = 0;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (if_id_instr !== mem_word(32'(4*(k-1)))) begin errors++; $display("FAIL seq_instr[%0d]: got %h want %h", k, if_id_instr, mem_word(32'(4*(k-1)))); end
            checks++; if (if_id_pc4 !== 32'(4*k)) begin errors++; $display("FAIL seq_pc4[%0d]: got %h want %h", k, if_id_pc4, 32'(4*k)); end
            checks++; if (imem_addr !== 32'(4*k) || if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_addr_valid[%0d]: got %h/%b want %h/1", k, imem_addr, if_id_valid, 32'(4*k)); end
        end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL seq_count: got %0d want 4", fetch_count); end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr[%0d]: got %h want 8", k, imem_addr); end
            checks++; if (if_id_instr !== mem_word(32'h4) || if_id_pc4 !== 32'h8 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid[%0d]: got %h/%h/%b want %h/8/1", k, if_id_instr, if_id_pc4, if_id_valid, mem_word(32'h4)); end
            checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count[%0d]: got %0d want 2", k, fetch_count); end
        end
        stall = 0;
        step();
        checks++; if (if_id_instr !== mem_word(32'h8) || if_id_pc4 !== 32'hC || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_resume: got %h/%h/%h want %h/c/c", if_id_instr, if_id_pc4, imem_addr, mem_word(32'h8)); end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL stall_resume_count: got %0d want 3", fetch_count); end
    endtask

    task automatic test_branch_stall();
        stall = 1; branch_taken = 1; branch_target = 32'h24;
        step();
        idle_inputs();
        checks++; if (imem_addr !== 32'h24) begin errors++; $display("FAIL br_addr: got %h want 24", imem_addr); end
        checks++; if (if_id_instr !== NOP || if_id_valid !== 1'b0) begin errors++; $display("FAIL br_bubble: got %h/%b want %h/0", if_id_instr, if_id_valid, NOP); end
        checks++; if (fetch_count !== 32'd3 || misalign !== 1'b0) begin errors++; $display("FAIL br_count_mis: got %0d/%b want 3/0", fetch_count, misalign); end
        step();
        checks++; if (if_id_instr !== mem_word(32'h24) || if_id_pc4 !== 32'h28 || if_id_valid !== 1'b1) begin errors++; $display("FAIL br_fetch: got %h/%h/%b want %h/28/1", if_id_instr, if_id_pc4, if_id_valid, mem_word(32'h24)); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL br_fetch_count: got %0d want 4", fetch_count); end
    endtask

    task automatic test_jump();
        jump = 1; jump_index = 26'h4;
        step();
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL jump_addr: got %h want 10", imem_addr); end
        checks++; if (if_id_instr !== NOP || if_id_valid !== 1'b0) begin errors++; $display("FAIL jump_bubble: got %h/%b want %h/0", if_id_instr, if_id_valid, NOP); end
        branch_taken = 1; branch_target = 32'h40;
        step();
        idle_inputs();
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL branch_over_jump: got %h want 40", imem_addr); end
    endtask

    task automatic test_flush();
        flush = 1;
        step();
        checks++; if (imem_addr !== 32'h44 || if_id_instr !== NOP || if_id_valid !== 1'b0) begin errors++; $display("FAIL flush: got %h/%h/%b want 44/%h/0", imem_addr, if_id_instr, if_id_valid, NOP); end
        stall = 1;
        step();
        checks++; if (imem_addr !== 32'h44 || if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_stall: got %h/%b want 44/0", imem_addr, if_id_valid); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL flush_count: got %0d want 4", fetch_count); end
        idle_inputs();
        step();
        checks++; if (if_id_instr !== mem_word(32'h44) || if_id_pc4 !== 32'h48 || fetch_count !== 32'd5) begin errors++; $display("FAIL flush_resume: got %h/%h/%0d want %h/48/5", if_id_instr, if_id_pc4, fetch_count, mem_word(32'h44)); end
    endtask

    task automatic test_misalign();
        branch_taken = 1; branch_target = 32'h1E;
        step();
        idle_inputs();
        checks++; if (imem_addr !== 32'h1C) begin errors++; $display("FAIL mis_addr: got %h want 1c", imem_addr); end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_set: got %b want 1", misalign); end
        jump = 1; jump_index = 26'h100;
        step();
        idle_inputs();
        checks++; if (imem_addr !== 32'h400 || misalign !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %h/%b want 400/1", imem_addr, misalign); end
    endtask

    task automatic test_wrap();
        branch_taken = 1; branch_target = 32'hFFFFFFFC;
        step();
        idle_inputs();
        checks++; if (imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pre: got %h want fffffffc", imem_addr); end
        step();
        checks++; if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap: got %h/%h want 0/0", imem_addr, if_id_pc4); end
        checks++; if (if_id_instr !== mem_word(32'hFFFFFFFC) || fetch_count !== 32'd6 || misalign !== 1'b1) begin errors++; $display("FAIL wrap_ifid: got %h/%0d/%b want %h/6/1", if_id_instr, fetch_count, misalign, mem_word(32'hFFFFFFFC)); end
    endtask

    task automatic test_async_reset();
        branch_taken = 1; branch_target = 32'h30;
        step();
        idle_inputs();
        checks++; if (imem_addr !== 32'h30) begin errors++; $display("FAIL ar_pre: got %h want 30", imem_addr); end
        stall = 1;
        #2 reset = 1;
        #1;
        checks++; if (imem_addr !== 32'h0 || if_id_instr !== NOP || if_id_valid !== 1'b0) begin errors++; $display("FAIL ar_clear: got %h/%h/%b want 0/%h/0", imem_addr, if_id_instr, if_id_valid, NOP); end
        checks++; if (misalign !== 1'b0 || fetch_count !== 32'h0 || if_id_pc4 !== 32'h0) begin errors++; $display("FAIL ar_clear2: got %b/%0d/%h want 0/0/0", misalign, fetch_count, if_id_pc4); end
        #2 reset = 0; stall = 0;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL ar_first_addr: got %h want 0", imem_addr); end
        step();
        checks++; if (if_id_instr !== mem_word(32'h0) || if_id_pc4 !== 32'h4 || imem_addr !== 32'h4) begin errors++; $display("FAIL ar_first_fetch: got %h/%h/%h want %h/4/4", if_id_instr, if_id_pc4, imem_addr, mem_word(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_stall();
        test_jump();
        test_flush();
        test_misalign();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
